// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive buffer with FIFO control register: DEPTH-entry FWFT FIFO or 1-entry holding register.
// Optional character-timeout interrupt is built when RX_TIMEOUT_EN is defined.
module uart_rx_fifo_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        fcr_write_data,
    input  logic              fcr_wr_en,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rd_en,
    input  logic              ovr_clr,
    input  logic              char_tick,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW:0]       fifo_count,
    output logic              data_ready,
    output logic              overrun,
    output logic              trig_irq,
    output logic              timeout_irq,
    output logic              fifoen,
    output logic [1:0]        rxfiftl,
    output logic              tx_clr
);

    localparam int unsigned CW    = AW + 1;
    localparam int unsigned TMR_W = 3;
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(4);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              fifoen_q,   fifoen_d;
    logic [1:0]        rxfiftl_q,  rxfiftl_d;
    logic              tx_clr_q,   tx_clr_d;
    logic [AW-1:0]     wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]     count_q,    count_d;
    logic [DATA_W-1:0] rd_data_q,  rd_data_d;
    logic              overrun_q,  overrun_d;

    logic          rx_clr_c;
    logic          push_req_c;
    logic          pop_ok_c;
    logic          full_c;
    logic          do_write_c;
    logic          ovr_write_c;
    logic          ovr_set_c;
    logic [CW-1:0] cap_c;
    logic [CW-1:0] thresh_c;
    logic          unused_c;

    // Transaction qualification; a clear (explicit or fifoen toggle) swallows same-cycle traffic
    always_comb begin
        rx_clr_c    = fcr_wr_en && (fcr_write_data[1] || (fcr_write_data[0] != fifoen_q));
        cap_c       = fifoen_q ? CW'(DEPTH) : CW'(1);
        full_c      = (count_q == cap_c);
        push_req_c  = rx_valid && !rx_clr_c;
        pop_ok_c    = rd_en && (count_q != '0) && !rx_clr_c;
        do_write_c  = push_req_c && (!full_c || pop_ok_c);
        ovr_write_c = push_req_c && full_c && !pop_ok_c && !fifoen_q;
        ovr_set_c   = push_req_c && full_c && !pop_ok_c;
    end

    // Next-state for FCR, pointers, count, head register and overrun
    always_comb begin
        fifoen_d  = fifoen_q;
        rxfiftl_d = rxfiftl_q;
        tx_clr_d  = 1'b0;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        overrun_d = overrun_q;

        if (fcr_wr_en) begin
            fifoen_d  = fcr_write_data[0];
            rxfiftl_d = fcr_write_data[5:4];
            tx_clr_d  = fcr_write_data[2];
        end

        if (rx_clr_c) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_write_c) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok_c) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_write_c && !pop_ok_c) begin
                count_d = count_q + CW'(1);
            end else if (pop_ok_c && !do_write_c) begin
                count_d = count_q - CW'(1);
            end

            // Head register tracks the entry at rd_ptr, so a pop exposes the next entry one cycle later
            if (ovr_write_c) begin
                rd_data_d = rx_data;
            end else if (pop_ok_c) begin
                if (count_q == CW'(1)) begin
                    if (do_write_c) begin
                        rd_data_d = rx_data;
                    end
                end else begin
                    rd_data_d = mem_q[rd_ptr_q + AW'(1)];
                end
            end else if (do_write_c && (count_q == '0)) begin
                rd_data_d = rx_data;
            end
        end

        if (ovr_clr) begin
            overrun_d = 1'b0;
        end
        if (ovr_set_c) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fifoen_q  <= 1'b0;
            rxfiftl_q <= 2'b00;
            tx_clr_q  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            fifoen_q  <= fifoen_d;
            rxfiftl_q <= rxfiftl_d;
            tx_clr_q  <= tx_clr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage array; holding-mode overwrite replaces the head in place
    always_ff @(posedge CLK) begin
        if (do_write_c) begin
            mem_q[wr_ptr_q] <= rx_data;
        end else if (ovr_write_c) begin
            mem_q[rd_ptr_q] <= rx_data;
        end
    end

`ifdef RX_TIMEOUT_EN
    logic [TMR_W-1:0] timer_q,   timer_d;
    logic             timeout_q, timeout_d;

    // Character timer: runs only while data sits idle in FIFO mode, saturates at the limit
    always_comb begin
        timer_d   = timer_q;
        timeout_d = timeout_q;
        if (rx_clr_c || push_req_c || pop_ok_c) begin
            timer_d   = '0;
            timeout_d = 1'b0;
        end else if (char_tick && fifoen_q && (count_q != '0) && (timer_q != TMR_LIMIT)) begin
            timer_d = timer_q + TMR_W'(1);
            if (timer_q == TMR_LIMIT - TMR_W'(1)) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    assign unused_c = ^{fcr_write_data[7:6], fcr_write_data[3]};
`else
    logic timeout_q;

    assign timeout_q = 1'b0;
    assign unused_c  = ^{char_tick, fcr_write_data[7:6], fcr_write_data[3]};
`endif

    // Trigger threshold decode from the stored level select
    always_comb begin
        unique case (rxfiftl_q)
            2'b00:   thresh_c = CW'(1);
            2'b01:   thresh_c = CW'(DEPTH / 4);
            2'b10:   thresh_c = CW'(DEPTH / 2);
            default: thresh_c = CW'(DEPTH - 2);
        endcase
    end

    always_comb begin
        rd_data     = rd_data_q;
        fifo_count  = count_q;
        data_ready  = (count_q != '0);
        overrun     = overrun_q;
        trig_irq    = fifoen_q ? (count_q >= thresh_c) : (count_q != '0);
        timeout_irq = timeout_q;
        fifoen      = fifoen_q;
        rxfiftl     = rxfiftl_q;
        tx_clr      = tx_clr_q;
    end

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Directed self-checking bench for uart_rx_fifo_ctrl (DEPTH=16, DATA_W=8).
module tb_uart_rx_fifo_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] fcr_write_data;
    logic       fcr_wr_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rd_en;
    logic       ovr_clr;
    logic       char_tick;
    logic [7:0] rd_data;
    logic [4:0] fifo_count;
    logic       data_ready;
    logic       overrun;
    logic       trig_irq;
    logic       timeout_irq;
    logic       fifoen;
    logic [1:0] rxfiftl;
    logic       tx_clr;

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx_fifo_ctrl #(.DATA_W(8), .DEPTH(16)) dut (
        .CLK(CLK), .RST(RST),
        .fcr_write_data(fcr_write_data), .fcr_wr_en(fcr_wr_en),
        .rx_data(rx_data), .rx_valid(rx_valid), .rd_en(rd_en),
        .ovr_clr(ovr_clr), .char_tick(char_tick),
        .rd_data(rd_data), .fifo_count(fifo_count), .data_ready(data_ready),
        .overrun(overrun), .trig_irq(trig_irq), .timeout_irq(timeout_irq),
        .fifoen(fifoen), .rxfiftl(rxfiftl), .tx_clr(tx_clr)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        rx_data = d; rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic fcr(input logic [7:0] v);
        fcr_write_data = v; fcr_wr_en = 1'b1;
        step();
        fcr_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step(); step();
        RST = 1'b0;
        n_tests++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %0h exp 0", rd_data); end
        n_tests++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", fifo_count); end
        n_tests++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_data_ready: got %b exp 0", data_ready); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b exp 0", overrun); end
        n_tests++; if (trig_irq !== 1'b0) begin n_fail++; $display("FAIL reset_trig: got %b exp 0", trig_irq); end
        n_tests++; if (timeout_irq !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b exp 0", timeout_irq); end
        n_tests++; if (fifoen !== 1'b0) begin n_fail++; $display("FAIL reset_fifoen: got %b exp 0", fifoen); end
        n_tests++; if (rxfiftl !== 2'b00) begin n_fail++; $display("FAIL reset_rxfiftl: got %0d exp 0", rxfiftl); end
        n_tests++; if (tx_clr !== 1'b0) begin n_fail++; $display("FAIL reset_tx_clr: got %b exp 0", tx_clr); end
    endtask

    task automatic test_fifo_order();
        fcr(8'h01);
        n_tests++; if (fifoen !== 1'b1) begin n_fail++; $display("FAIL order_fifoen: got %b exp 1", fifoen); end
        push(8'h41);
        n_tests++; if (data_ready !== 1'b1 || rd_data !== 8'h41) begin n_fail++; $display("FAIL order_first_latency: got dr=%b rd=%0h exp dr=1 rd=41", data_ready, rd_data); end
        push(8'h42);
        push(8'h43);
        n_tests++; if (fifo_count !== 5'd3) begin n_fail++; $display("FAIL order_count3: got %0d exp 3", fifo_count); end
        pop();
        n_tests++; if (rd_data !== 8'h42) begin n_fail++; $display("FAIL order_head2: got %0h exp 42", rd_data); end
        pop();
        n_tests++; if (rd_data !== 8'h43) begin n_fail++; $display("FAIL order_head3: got %0h exp 43", rd_data); end
        pop();
        n_tests++; if (data_ready !== 1'b0 || fifo_count !== 5'd0) begin n_fail++; $display("FAIL order_empty: got dr=%b cnt=%0d exp dr=0 cnt=0", data_ready, fifo_count); end
    endtask

    task automatic test_trigger();
        fcr(8'h21);
        n_tests++; if (rxfiftl !== 2'b10) begin n_fail++; $display("FAIL trig_rxfiftl: got %0d exp 2", rxfiftl); end
        for (int i = 0; i < 7; i++) push(8'(i));
        n_tests++; if (trig_irq !== 1'b0 || fifo_count !== 5'd7) begin n_fail++; $display("FAIL trig_below: got trig=%b cnt=%0d exp trig=0 cnt=7", trig_irq, fifo_count); end
        push(8'h07);
        n_tests++; if (trig_irq !== 1'b1) begin n_fail++; $display("FAIL trig_at8: got %b exp 1", trig_irq); end
        pop();
        n_tests++; if (trig_irq !== 1'b0 || fifo_count !== 5'd7) begin n_fail++; $display("FAIL trig_after_pop: got trig=%b cnt=%0d exp trig=0 cnt=7", trig_irq, fifo_count); end
        fcr(8'h11);
        n_tests++; if (trig_irq !== 1'b1 || fifo_count !== 5'd7) begin n_fail++; $display("FAIL trig_level4: got trig=%b cnt=%0d exp trig=1 cnt=7", trig_irq, fifo_count); end
        fcr(8'h31);
        n_tests++; if (trig_irq !== 1'b0 || fifo_count !== 5'd7) begin n_fail++; $display("FAIL trig_level14: got trig=%b cnt=%0d exp trig=0 cnt=7", trig_irq, fifo_count); end
        fcr(8'h03);
        n_tests++; if (fifo_count !== 5'd0 || rxfiftl !== 2'b00) begin n_fail++; $display("FAIL trig_rx_clear: got cnt=%0d lvl=%0d exp cnt=0 lvl=0", fifo_count, rxfiftl); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp_d;
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
        n_tests++; if (fifo_count !== 5'd16 || rd_data !== 8'h80) begin n_fail++; $display("FAIL ovr_full: got cnt=%0d rd=%0h exp cnt=16 rd=80", fifo_count, rd_data); end
        push(8'h55);
        n_tests++; if (overrun !== 1'b1 || fifo_count !== 5'd16 || rd_data !== 8'h80) begin n_fail++; $display("FAIL ovr_drop: got ovr=%b cnt=%0d rd=%0h exp ovr=1 cnt=16 rd=80", overrun, fifo_count, rd_data); end
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b exp 0", overrun); end
        rx_data = 8'h77; rx_valid = 1'b1; ovr_clr = 1'b1; step(); rx_valid = 1'b0; ovr_clr = 1'b0;
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins: got %b exp 1", overrun); end
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        rx_data = 8'h66; rx_valid = 1'b1; rd_en = 1'b1; step(); rx_valid = 1'b0; rd_en = 1'b0;
        n_tests++; if (fifo_count !== 5'd16 || overrun !== 1'b0 || rd_data !== 8'h81) begin n_fail++; $display("FAIL ovr_push_pop_full: got cnt=%0d ovr=%b rd=%0h exp cnt=16 ovr=0 rd=81", fifo_count, overrun, rd_data); end
        for (int i = 0; i < 16; i++) begin
            exp_d = (i < 15) ? 8'(8'h81 + i) : 8'h66;
            n_tests++; if (rd_data !== exp_d) begin n_fail++; $display("FAIL ovr_drain_%0d: got %0h exp %0h", i, rd_data, exp_d); end
            pop();
        end
        n_tests++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL ovr_drained: got %0d exp 0", fifo_count); end
        pop();
        n_tests++; if (fifo_count !== 5'd0 || rd_data !== 8'h66) begin n_fail++; $display("FAIL ovr_underflow: got cnt=%0d rd=%0h exp cnt=0 rd=66", fifo_count, rd_data); end
    endtask

    task automatic test_holding();
        fcr(8'h00);
        n_tests++; if (fifoen !== 1'b0 || fifo_count !== 5'd0) begin n_fail++; $display("FAIL hold_mode: got en=%b cnt=%0d exp en=0 cnt=0", fifoen, fifo_count); end
        push(8'h10);
        push(8'h20);
        n_tests++; if (rd_data !== 8'h20 || overrun !== 1'b1 || fifo_count !== 5'd1) begin n_fail++; $display("FAIL hold_overwrite: got rd=%0h ovr=%b cnt=%0d exp rd=20 ovr=1 cnt=1", rd_data, overrun, fifo_count); end
        n_tests++; if (trig_irq !== 1'b1) begin n_fail++; $display("FAIL hold_trig: got %b exp 1", trig_irq); end
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        rx_data = 8'h30; rx_valid = 1'b1; rd_en = 1'b1; step(); rx_valid = 1'b0; rd_en = 1'b0;
        n_tests++; if (rd_data !== 8'h30 || fifo_count !== 5'd1 || overrun !== 1'b0) begin n_fail++; $display("FAIL hold_push_pop: got rd=%0h cnt=%0d ovr=%b exp rd=30 cnt=1 ovr=0", rd_data, fifo_count, overrun); end
        pop();
        n_tests++; if (fifo_count !== 5'd0 || trig_irq !== 1'b0) begin n_fail++; $display("FAIL hold_pop: got cnt=%0d trig=%b exp cnt=0 trig=0", fifo_count, trig_irq); end
        push(8'h40);
        push(8'h50);
    endtask

    task automatic test_clear_txclr();
        fcr(8'h01);
        n_tests++; if (fifo_count !== 5'd0 || overrun !== 1'b1 || tx_clr !== 1'b0) begin n_fail++; $display("FAIL clr_mode_switch: got cnt=%0d ovr=%b txc=%b exp cnt=0 ovr=1 txc=0", fifo_count, overrun, tx_clr); end
        for (int i = 0; i < 5; i++) push(8'(8'hA0 + i));
        n_tests++; if (fifo_count !== 5'd5) begin n_fail++; $display("FAIL clr_fill5: got %0d exp 5", fifo_count); end
        fcr_write_data = 8'h07; fcr_wr_en = 1'b1; rx_data = 8'h99; rx_valid = 1'b1;
        step();
        fcr_wr_en = 1'b0; rx_valid = 1'b0;
        n_tests++; if (fifo_count !== 5'd0 || data_ready !== 1'b0) begin n_fail++; $display("FAIL clr_flush: got cnt=%0d dr=%b exp cnt=0 dr=0", fifo_count, data_ready); end
        n_tests++; if (tx_clr !== 1'b1) begin n_fail++; $display("FAIL clr_tx_pulse: got %b exp 1", tx_clr); end
        n_tests++; if (overrun !== 1'b1 || fifoen !== 1'b1) begin n_fail++; $display("FAIL clr_keep_ovr: got ovr=%b en=%b exp ovr=1 en=1", overrun, fifoen); end
        step();
        n_tests++; if (tx_clr !== 1'b0 || fifo_count !== 5'd0) begin n_fail++; $display("FAIL clr_tx_one_cycle: got txc=%b cnt=%0d exp txc=0 cnt=0", tx_clr, fifo_count); end
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    endtask

    task automatic test_timeout();
        push(8'hC1);
        push(8'hC2);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                n_tests++; if (timeout_irq !== 1'b0) begin n_fail++; $display("FAIL to_before_4th: got %b exp 0", timeout_irq); end
            end
            char_tick = 1'b1; step(); char_tick = 1'b0;
            step();
        end
`ifdef RX_TIMEOUT_EN
        n_tests++; if (timeout_irq !== 1'b1) begin n_fail++; $display("FAIL to_fired: got %b exp 1", timeout_irq); end
        pop();
        n_tests++; if (timeout_irq !== 1'b0 || fifo_count !== 5'd1) begin n_fail++; $display("FAIL to_pop_clears: got to=%b cnt=%0d exp to=0 cnt=1", timeout_irq, fifo_count); end
`else
        n_tests++; if (timeout_irq !== 1'b0 || fifo_count !== 5'd2) begin n_fail++; $display("FAIL to_disabled: got to=%b cnt=%0d exp to=0 cnt=2", timeout_irq, fifo_count); end
`endif
    endtask

    initial begin
        RST = 1'b1; fcr_write_data = 8'h00; fcr_wr_en = 1'b0;
        rx_data = 8'h00; rx_valid = 1'b0; rd_en = 1'b0;
        ovr_clr = 1'b0; char_tick = 1'b0;
        test_reset();
        test_fifo_order();
        test_trigger();
        test_overrun();
        test_holding();
        test_clear_txclr();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
